interrupt_vector_ack: RTL and testbench
=======================================

// Module: interrupt_vector_ack
// PURPOSE
//  Downstream stage of interrupt_manager. Turns latched pending lines plus n_int into a Z80 IM2 request.
//  Answers the M1+IORQ acknowledge with a priority-encoded vector. Pulses the manager's rd input so the latches clear.
//  Sits between interrupt_manager and the CPU bus mux.
// PARAMETERS
//  VECTOR_BASE   8'h80  IM2 vector base; bits [4:0] must be zero
//  SYNC_STAGES   2      flops on n_m1_i/n_iorq_i synchroniser (>=2)
//  HOLDOFF       4      cycles in HOLD after ack before re-arming (>=3)
// PORTS
//  fast_clock_i    in   1  system fast clock, all logic on posedge
//  n_reset_i       in   1  asynchronous, active-low reset
//  pending_i       in   8  latched lines from interrupt_manager dat_o
//  n_int_i         in   1  interrupt_manager n_int_o (low = any pending)
//  mask_i          in   8  1 = line masked, ignored for request/priority
//  n_m1_i          in   1  Z80 /M1, asynchronous to fast_clock_i
//  n_iorq_i        in   1  Z80 /IORQ, asynchronous to fast_clock_i
//  n_int_o         out  1  Z80 /INT request
//  vec_o           out  8  vector byte for data bus
//  vec_oe_o        out  1  drive vec_o onto CPU data bus
//  ack_rd_o        out  1  to interrupt_manager rd_i; falling edge clears latches
//  active_o        out  8  one-hot line serviced by last ack (0 = spurious)
//  snap_o          out  8  pending_i captured at last ack
// BEHAVIOUR
//  Reset values: n_int_o=1, vec_o=0, vec_oe_o=0, ack_rd_o=0, active_o=0, snap_o=0, state IDLE, counter 0.
//  Reset is async assert and sync release; mid-cycle reset drops vec_oe_o immediately.
//  n_m1_i/n_iorq_i pass SYNC_STAGES flops, reset to 1. ack_seen = synced m1 low AND synced iorq low.
//  req = |(pending_i & ~mask_i) AND !n_int_i.
//  States: IDLE -> REQ -> ACK -> HOLD -> IDLE.
//   IDLE: n_int_o=1. If req, go to REQ next cycle.
//   REQ: n_int_o=0 (registered).
//    If !req and !ack_seen, return to IDLE and set n_int_o=1 (request withdrawn or masked).
//    If ack_seen (this wins over withdrawal), go to ACK in the same cycle and capture:
//     idx = lowest set bit of pending_i & ~mask_i (bit0 highest priority).
//     vec_o = VECTOR_BASE | {idx,1'b0}.
//     active_o = 1<<idx.
//     snap_o = pending_i.
//     vec_oe_o=1, ack_rd_o=1, n_int_o=1.
//    If nothing is unmasked at ack (spurious): vec_o = VECTOR_BASE|8'h10, active_o=0, same handshake.
//   ACK: hold vec_o, vec_oe_o, ack_rd_o. Leave when synced n_iorq goes high:
//    vec_oe_o=0, ack_rd_o=0, counter=HOLDOFF-1, go to HOLD.
//   HOLD: n_int_o=1. Decrement counter; at 0 go to IDLE. This covers the manager's edge-detect plus negedge latch delay.
//    Sources raised during HOLD stay latched upstream and are serviced from IDLE.
//  Latency: req to n_int_o low = 2 cycles. iorq high to vec_oe_o low = SYNC_STAGES+1 cycles.
//  ack_rd_o is high for at least one cycle per ack; the manager clears all 8 latches.
//  Lower-priority lines are therefore lost unless software reads snap_o; this is the intended contract.
//  vec_o is stable whenever vec_oe_o=1. mask_i changes in ACK/HOLD have no effect until IDLE.
//  Idle ack cycles (no REQ) are ignored: no vec_oe_o, no ack_rd_o.
// STRUCTURE
//  Package interrupt_pkg holds:
//   state localparams IDLE/REQ/ACK/HOLD (2-bit);
//   SPURIOUS_OFS=8'h10;
//   prio_enc8 function returning {valid, idx[2:0]}.
//  Sub-module bus_sync #(STAGES) does the async-reset (to 1) multi-flop synchroniser; one instance per Z80 strobe.
//  FSM, counter and capture registers live in the top.
// TESTING
//  pending=8'h24, mask=0, ack after REQ -> vec_o=8'h84, active_o=8'h04, snap_o=8'h24, ack_rd_o falls after IORQ high.
//  pending=8'h01, mask=8'h01 -> n_int_o stays 1, no state change; clear mask -> n_int_o low 2 cycles later.
//  REQ then pending masked before ack -> back to IDLE, n_int_o=1; later stray ack -> vec_oe_o stays 0.
//  Ack same cycle req withdrawn -> spurious: vec_o=8'h90, active_o=0, ack_rd_o pulses.
//  n_reset_i low during ACK -> vec_oe_o=0, ack_rd_o=0, n_int_o=1 asynchronously; outputs at reset values after release.
//  New line raised in HOLD -> no n_int_o until HOLDOFF expires, then normal request and vector.

Source files
------------

// File: rtl/interrupt_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_pkg
//   Shared types and helpers for the Z80 IM2 acknowledge stage.
//   - state_e      : FSM encoding IDLE/REQ/ACK/HOLD (2-bit)
//   - SPURIOUS_OFS : vector offset returned when no unmasked line is pending
//   - prio_enc8    : lowest-set-bit priority encoder, returns {valid, idx}
// -----------------------------------------------------------------------------
package interrupt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2,
      HOLD = 2'd3
   } state_e;

   localparam logic [7:0] SPURIOUS_OFS = 8'h10;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } prio_t;

   // Bit 0 is the highest priority; scanning from the top down lets the
   // lowest set bit overwrite any earlier hit.
   function automatic prio_t prio_enc8(input logic [7:0] lines);
      prio_t res;
      res = '0;
      for (int i = 7; i >= 0; i--) begin
         if (lines[i]) begin
            res.valid = 1'b1;
            res.idx   = 3'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/interrupt_vector_ack_bus_sync.sv
// -----------------------------------------------------------------------------
// bus_sync
//   Multi-flop synchroniser for an asynchronous, active-low Z80 strobe.
//   Flops reset to 1 so a strobe reads as inactive while in reset.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output (STAGES cycles of latency)
// -----------------------------------------------------------------------------
module bus_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge value of its neighbour; blocking here would
   // collapse the chain into a single flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/interrupt_vector_ack.sv
// -----------------------------------------------------------------------------
// interrupt_vector_ack
//   Turns latched pending lines from interrupt_manager into a Z80 IM2 /INT
//   request, answers the M1+IORQ acknowledge with a priority-encoded vector,
//   and pulses ack_rd_o so the manager clears its latches.
//
//   fast_clock_i : system clock, all logic on posedge
//   n_reset_i    : asynchronous active-low reset (released synchronously)
//   pending_i    : latched lines from interrupt_manager
//   n_int_i      : manager's /INT (low = something pending)
//   mask_i       : 1 = line ignored for request and priority
//   n_m1_i       : Z80 /M1 (asynchronous)
//   n_iorq_i     : Z80 /IORQ (asynchronous)
//   n_int_o      : Z80 /INT request
//   vec_o        : IM2 vector byte
//   vec_oe_o     : drive vec_o onto the CPU data bus
//   ack_rd_o     : to manager rd_i; falling edge clears the latches
//   active_o     : one-hot line serviced by the last ack (0 = spurious)
//   snap_o       : pending_i captured at the last ack
// -----------------------------------------------------------------------------
module interrupt_vector_ack
   import interrupt_pkg::*;
#(
   parameter logic [7:0]  VECTOR_BASE = 8'h80,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLDOFF     = 4
) (
   input  logic       fast_clock_i,
   input  logic       n_reset_i,
   input  logic [7:0] pending_i,
   input  logic       n_int_i,
   input  logic [7:0] mask_i,
   input  logic       n_m1_i,
   input  logic       n_iorq_i,
   output logic       n_int_o,
   output logic [7:0] vec_o,
   output logic       vec_oe_o,
   output logic       ack_rd_o,
   output logic [7:0] active_o,
   output logic [7:0] snap_o
);

   localparam int unsigned CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   // --------------------------------------------------------------------------
   // Reset: asserted asynchronously, released on a clock edge so no flop sees
   // the release in the middle of a setup window.
   // --------------------------------------------------------------------------
   logic [1:0] rst_sync_q;
   logic [1:0] rst_sync_d;
   logic       rst_n;

   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
   end

   always_ff @(posedge fast_clock_i or negedge n_reset_i) begin
      if (!n_reset_i) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   assign rst_n = rst_sync_q[1];

   // --------------------------------------------------------------------------
   // Z80 strobe synchronisers
   // --------------------------------------------------------------------------
   logic m1_s;
   logic iorq_s;
   logic ack_seen;

   bus_sync #(.STAGES(SYNC_STAGES)) u_sync_m1 (
      .clk   (fast_clock_i),
      .rst_n (rst_n),
      .d     (n_m1_i),
      .q     (m1_s)
   );

   bus_sync #(.STAGES(SYNC_STAGES)) u_sync_iorq (
      .clk   (fast_clock_i),
      .rst_n (rst_n),
      .d     (n_iorq_i),
      .q     (iorq_s)
   );

   assign ack_seen = !m1_s && !iorq_s;

   // --------------------------------------------------------------------------
   // Request qualification and priority
   // --------------------------------------------------------------------------
   logic [7:0] unmasked;
   logic       req;
   prio_t      prio;

   assign unmasked = pending_i & ~mask_i;
   assign req      = (|unmasked) && !n_int_i;
   assign prio     = prio_enc8(unmasked);

   // --------------------------------------------------------------------------
   // FSM, hold-off counter and capture registers
   // --------------------------------------------------------------------------
   state_e           state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             n_int_q,  n_int_d;
   logic [7:0]       vec_q,    vec_d;
   logic             vec_oe_q, vec_oe_d;
   logic             ack_rd_q, ack_rd_d;
   logic [7:0]       active_q, active_d;
   logic [7:0]       snap_q,   snap_d;

   // NOTE: every signal written here is given its hold value first, so no path
   // through the case statement leaves one unassigned and infers a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      n_int_d  = n_int_q;
      vec_d    = vec_q;
      vec_oe_d = vec_oe_q;
      ack_rd_d = ack_rd_q;
      active_d = active_q;
      snap_d   = snap_q;

      unique case (state_q)
         IDLE: begin
            n_int_d = 1'b1;
            if (req) begin
               state_d = REQ;
            end
         end

         REQ: begin
            // Acknowledge outranks withdrawal: once the CPU is in its ack cycle
            // it will read a vector no matter what, so it must get one.
            if (ack_seen) begin
               state_d  = ACK;
               n_int_d  = 1'b1;
               vec_oe_d = 1'b1;
               ack_rd_d = 1'b1;
               snap_d   = pending_i;
               if (prio.valid) begin
                  vec_d    = VECTOR_BASE | {4'b0000, prio.idx, 1'b0};
                  active_d = 8'(1) << prio.idx;
               end else begin
                  vec_d    = VECTOR_BASE | SPURIOUS_OFS;
                  active_d = '0;
               end
            end else if (!req) begin
               state_d = IDLE;
               n_int_d = 1'b1;
            end else begin
               n_int_d = 1'b0;
            end
         end

         ACK: begin
            if (iorq_s) begin
               state_d  = HOLD;
               vec_oe_d = 1'b0;
               ack_rd_d = 1'b0;
               cnt_d    = CNT_W'(HOLDOFF - 1);
            end
         end

         HOLD: begin
            // Gives the manager time to see the ack_rd_o edge and release its
            // latches before a stale n_int_i can re-trigger a request.
            n_int_d = 1'b1;
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge fast_clock_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         n_int_q  <= 1'b1;
         vec_q    <= '0;
         vec_oe_q <= 1'b0;
         ack_rd_q <= 1'b0;
         active_q <= '0;
         snap_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         n_int_q  <= n_int_d;
         vec_q    <= vec_d;
         vec_oe_q <= vec_oe_d;
         ack_rd_q <= ack_rd_d;
         active_q <= active_d;
         snap_q   <= snap_d;
      end
   end

   assign n_int_o  = n_int_q;
   assign vec_o    = vec_q;
   assign vec_oe_o = vec_oe_q;
   assign ack_rd_o = ack_rd_q;
   assign active_o = active_q;
   assign snap_o   = snap_q;

endmodule

// File: tb/tb_interrupt_vector_ack.sv
// -----------------------------------------------------------------------------
// tb_interrupt_vector_ack
//   Directed vectors with hand-computed expectations for interrupt_vector_ack
//   (VECTOR_BASE=8'h80, SYNC_STAGES=2, HOLDOFF=4). Inputs change 1 time unit
//   after a rising edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_interrupt_vector_ack;

   logic       clk;
   logic       n_reset;
   logic [7:0] pending;
   logic       n_int_in;
   logic [7:0] mask;
   logic       n_m1;
   logic       n_iorq;
   logic       n_int_out;
   logic [7:0] vec;
   logic       vec_oe;
   logic       ack_rd;
   logic [7:0] active;
   logic [7:0] snap;

   int n_vec = 0;
   int n_err = 0;

   interrupt_vector_ack #(
      .VECTOR_BASE (8'h80),
      .SYNC_STAGES (2),
      .HOLDOFF     (4)
   ) dut (
      .fast_clock_i (clk),
      .n_reset_i    (n_reset),
      .pending_i    (pending),
      .n_int_i      (n_int_in),
      .mask_i       (mask),
      .n_m1_i       (n_m1),
      .n_iorq_i     (n_iorq),
      .n_int_o      (n_int_out),
      .vec_o        (vec),
      .vec_oe_o     (vec_oe),
      .ack_rd_o     (ack_rd),
      .active_o     (active),
      .snap_o       (snap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ack_on();
      n_m1   = 1'b0;
      n_iorq = 1'b0;
   endtask

   task automatic ack_off();
      n_m1   = 1'b1;
      n_iorq = 1'b1;
   endtask

   initial begin
      n_reset  = 1'b0;
      pending  = 8'h00;
      n_int_in = 1'b1;
      mask     = 8'h00;
      n_m1     = 1'b1;
      n_iorq   = 1'b1;

      // ---- reset state ----
      step(2);
      check("rst_n_int",  n_int_out, 1);
      check("rst_vec",    vec,       8'h00);
      check("rst_vec_oe", vec_oe,    0);
      check("rst_ack_rd", ack_rd,    0);
      check("rst_active", active,    8'h00);
      check("rst_snap",   snap,      8'h00);
      n_reset = 1'b1;
      step(4);

      // ---- basic request/ack: pending 24 -> idx 2 -> vector 84 ----
      pending  = 8'h24;
      n_int_in = 1'b0;
      step(1);
      check("t1_n_int_1cyc", n_int_out, 1);
      step(1);
      check("t1_n_int_2cyc", n_int_out, 0);
      ack_on();
      step(2);
      check("t1_oe_pre", vec_oe, 0);
      step(1);
      check("t1_oe",     vec_oe,    1);
      check("t1_vec",    vec,       8'h84);
      check("t1_active", active,    8'h04);
      check("t1_snap",   snap,      8'h24);
      check("t1_ack_rd", ack_rd,    1);
      check("t1_n_int",  n_int_out, 1);
      ack_off();
      step(2);
      check("t1_ack_rd_hold", ack_rd, 1);
      check("t1_vec_stable",  vec,    8'h84);
      step(1);
      check("t1_ack_rd_fall", ack_rd, 0);
      check("t1_oe_fall",     vec_oe, 0);
      pending  = 8'h00;
      n_int_in = 1'b1;
      step(5);

      // ---- masked line: no request until mask cleared ----
      pending  = 8'h01;
      mask     = 8'h01;
      n_int_in = 1'b0;
      step(4);
      check("t2_masked_n_int", n_int_out, 1);
      check("t2_masked_oe",    vec_oe,    0);
      mask = 8'h00;
      step(1);
      check("t2_unmask_1cyc", n_int_out, 1);
      step(1);
      check("t2_unmask_2cyc", n_int_out, 0);
      pending  = 8'h00;
      n_int_in = 1'b1;
      step(1);
      check("t2_withdraw", n_int_out, 1);
      step(2);

      // ---- masked before ack, then stray ack ignored ----
      pending  = 8'h02;
      n_int_in = 1'b0;
      step(2);
      check("t3_req", n_int_out, 0);
      mask = 8'h02;
      step(1);
      check("t3_masked_idle", n_int_out, 1);
      ack_on();
      step(6);
      check("t3_stray_oe",     vec_oe, 0);
      check("t3_stray_ack_rd", ack_rd, 0);
      check("t3_stray_n_int",  n_int_out, 1);
      ack_off();
      pending  = 8'h00;
      mask     = 8'h00;
      n_int_in = 1'b1;
      step(3);

      // ---- spurious: request withdrawn in the cycle ack is seen ----
      pending  = 8'h08;
      n_int_in = 1'b0;
      step(2);
      check("t4_req", n_int_out, 0);
      ack_on();
      step(2);
      pending  = 8'h00;
      n_int_in = 1'b1;
      step(1);
      check("t4_oe",     vec_oe, 1);
      check("t4_vec",    vec,    8'h90);
      check("t4_active", active, 8'h00);
      check("t4_snap",   snap,   8'h00);
      check("t4_ack_rd", ack_rd, 1);
      ack_off();
      step(3);
      check("t4_ack_rd_fall", ack_rd, 0);
      step(5);

      // ---- asynchronous reset while in ACK ----
      pending  = 8'h10;
      n_int_in = 1'b0;
      step(2);
      ack_on();
      step(3);
      check("t5_oe",  vec_oe, 1);
      check("t5_vec", vec,    8'h88);
      #3 n_reset = 1'b0;
      #1;
      check("t5_async_oe",     vec_oe,    0);
      check("t5_async_ack_rd", ack_rd,    0);
      check("t5_async_n_int",  n_int_out, 1);
      ack_off();
      pending  = 8'h00;
      n_int_in = 1'b1;
      #2 n_reset = 1'b1;
      step(4);
      check("t5_post_vec",    vec,       8'h00);
      check("t5_post_active", active,    8'h00);
      check("t5_post_snap",   snap,      8'h00);
      check("t5_post_oe",     vec_oe,    0);
      check("t5_post_n_int",  n_int_out, 1);

      // ---- priority with a mask, then new line raised during HOLD ----
      pending  = 8'hFF;
      mask     = 8'h01;
      n_int_in = 1'b0;
      step(2);
      ack_on();
      step(3);
      check("t6_vec",    vec,    8'h82);
      check("t6_active", active, 8'h02);
      check("t6_snap",   snap,   8'hFF);
      ack_off();
      step(3);
      check("t6_oe_fall", vec_oe, 0);
      pending  = 8'h80;
      mask     = 8'h00;
      n_int_in = 1'b0;
      step(5);
      check("t6_hold_n_int", n_int_out, 1);
      step(1);
      check("t6_rearm_n_int", n_int_out, 0);
      ack_on();
      step(3);
      check("t6_new_vec",    vec,    8'h8E);
      check("t6_new_active", active, 8'h80);
      check("t6_new_snap",   snap,   8'h80);
      ack_off();
      step(3);
      pending  = 8'h00;
      n_int_in = 1'b1;
      step(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
